lfsr_gen: RTL
=============

Name: lfsr_gen

Overview:
Parametrised successor to the fixed 16-bit LFSR. It generates pseudo-random sequences for codeword generation and detector stimulus. Width, feedback polynomial, structure (Fibonacci/Galois) and shifts-per-clock are all configurable. It adds runtime seed load, period-completion detection against the last loaded seed, and zero-state lockup recovery.

Parameters:
WIDTH, 16, register width; legal range 3..32
TAPS, 16'hB400, polynomial mask; bit i = coefficient of x^(i+1); the x^0 term is implicit
SEED, 1, reset state; a value of 0 is replaced by 1
GALOIS, 0, 0 = Fibonacci structure, 1 = Galois structure
STEPS, 1, shifts per enabled clock; legal range 1..WIDTH

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
sh_en  in  1  advance the state by STEPS shifts this cycle
load  in  1  load seed_in this cycle; has priority over sh_en
seed_in  in  WIDTH  runtime seed
q_out  out  WIDTH  current state (registered)
max_tick  out  1  one-cycle pulse: the sequence has returned to the anchor seed
seed_err  out  1  one-cycle pulse: load was attempted with seed_in == 0
lockup  out  1  one-cycle pulse: an all-zero state was detected and recovered

Behaviour:
- Reset (asynchronous, active-high, clk is one clock; rst asserted at any time):
  - q_out = anchor = SEED (or 1 if SEED == 0).
  - max_tick = seed_err = lockup = 0.
  - Reset asserted mid-sequence aborts the sequence immediately.
- Single shift, Fibonacci:
  - fb = ^(s & TAPS)
  - s' = {s[W-2:0], fb}
- Single shift, Galois:
  - s' = {s[W-2:0], 1'b0} ^ (s[W-1] ? {TAPS[W-2:0], 1'b1} : 0)
- Per-cycle priority is load > lockup recovery > sh_en > hold.
- load = 1:
  - If seed_in != 0: q_out and anchor take seed_in on the next edge.
  - If seed_in == 0: q_out and anchor take 1, and seed_err pulses high for exactly one cycle.
  - In either case no shift occurs that cycle and max_tick stays 0.
- Lockup recovery: if q_out == 0 while sh_en = 1 and load = 0, q_out takes 1 and lockup pulses. This state is unreachable in normal operation and only arises from SEU or forced state.
- sh_en = 1 (no load, no lockup):
  - The combinational chain applies STEPS single shifts, producing intermediates i1..iSTEPS; q_out takes iSTEPS.
  - max_tick is registered: it is high in the cycle after the update if any intermediate equals anchor.
  - This means a period-wrap crossed mid-cycle is still flagged.
- sh_en = 0: q_out holds and all pulse outputs go to 0.
- Latency:
  - q_out is valid one clock after the enabling edge.
  - All pulse outputs align with the q_out update they describe.
- For a primitive TAPS, max_tick first fires after exactly 2^WIDTH-1 shifts from a load or reset. With STEPS > 1 it fires on the cycle containing that shift.
- The anchor changes only on reset or load.

Optional Feature:
LFSR_PERIOD_CNT_EN
- Defined:
  - Adds output period_cnt [WIDTH-1:0], which counts shifts since the last anchor hit, load or reset.
  - It increments by STEPS per enabled cycle, modulo 2^WIDTH.
  - It clears to 0 on reset, on load, and on a max_tick cycle. On a max_tick cycle it instead takes the number of shifts taken after the anchor hit within that cycle.
  - Adds output period_len [WIDTH-1:0], which latches the measured period at each max_tick.
  - Both reset to 0.
- Not defined: neither port nor its logic exists; all other behaviour is unchanged.

Decomposition:
- Package lfsr_pkg:
  - lfsr_mode enum (FIBONACCI, GALOIS)
  - Named primitive-polynomial constants: TAPS_4 = 4'hC, TAPS_8 = 8'hB8, TAPS_16 = 16'hB400, TAPS_19 = 19'h72000, TAPS_32 = 32'h80200003
  - The MAX_WIDTH = 32 constant
- Sub-module lfsr_step: purely combinational single-shift next-state function, parametrised by WIDTH/TAPS/GALOIS. lfsr_gen instantiates STEPS copies in a generate chain.

Test Plan:
1. WIDTH=4, TAPS=4'hC, Fibonacci, STEPS=1, reset, sh_en=1 -> q_out 0001, 0010, 0100, 1001, 0011; max_tick asserted first after exactly 15 shifts, then every 15 cycles.
2. WIDTH=16, TAPS=16'hB400, reset then sh_en=1 for 65535 cycles -> exactly one max_tick, at shift 65535; no repeated state before it (scoreboard bitmap).
3. Load seed_in=16'hACE1 with sh_en=1 the same cycle -> q_out=ACE1 next cycle with no shift; next max_tick after 65535 shifts. Load seed_in=0 -> q_out=0001 and a single seed_err pulse.
4. WIDTH=8, TAPS=8'hB8, STEPS=4 versus a STEPS=1 reference model -> q_out equals every 4th reference state; max_tick fires on the cycle containing shift 255.
5. Force q_out=0, sh_en=1 -> next q_out=1 with a lockup pulse. Assert rst mid-sequence between edges -> q_out=SEED immediately, all pulses 0.
6. With LFSR_PERIOD_CNT_EN defined, WIDTH=4, TAPS=4'hC -> period_len=15 after the first max_tick; period_cnt returns to 0 on load.

Source files
------------

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR types, width limit and primitive-polynomial tap masks.
package lfsr_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic {
    FIBONACCI = 1'b0,
    GALOIS    = 1'b1
  } lfsr_mode;

  localparam logic [3:0]  TAPS_4  = 4'hC;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [18:0] TAPS_19 = 19'h72000;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

  // The all-zero state is a fixed point of every LFSR, so it is never a usable seed.
  function automatic logic [MAX_WIDTH-1:0] nonzero_seed(input logic [MAX_WIDTH-1:0] s);
    return (s == '0) ? MAX_WIDTH'(1) : s;
  endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// rtl/lfsr_gen_if.sv - control/status bundle of lfsr_gen; period_cnt/period_len exist only with LFSR_PERIOD_CNT_EN.
interface lfsr_gen_if #(
  parameter int WIDTH = 16
);
  import lfsr_pkg::*;

  logic             sh_en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] q_out;
  logic             max_tick;
  logic             seed_err;
  logic             lockup;
`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] period_cnt;
  logic [WIDTH-1:0] period_len;

  modport master (
    output sh_en, load, seed_in,
    input  q_out, max_tick, seed_err, lockup, period_cnt, period_len
  );
  modport slave (
    input  sh_en, load, seed_in,
    output q_out, max_tick, seed_err, lockup, period_cnt, period_len
  );
`else
  modport master (
    output sh_en, load, seed_in,
    input  q_out, max_tick, seed_err, lockup
  );
  modport slave (
    input  sh_en, load, seed_in,
    output q_out, max_tick, seed_err, lockup
  );
`endif
endinterface

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - one combinational LFSR shift, Fibonacci or Galois form.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
  parameter lfsr_mode         MODE  = FIBONACCI
) (
  input  logic [WIDTH-1:0] s_in,
  output logic [WIDTH-1:0] s_out
);

  always_comb begin
    s_out = '0;
    if (MODE == GALOIS) begin
      s_out = {s_in[WIDTH-2:0], 1'b0} ^ (s_in[WIDTH-1] ? {TAPS[WIDTH-2:0], 1'b1} : '0);
    end else begin
      s_out = {s_in[WIDTH-2:0], ^(s_in & TAPS)};
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - configurable LFSR with seed load, anchor-return detection and zero-state recovery.
// Define LFSR_PERIOD_CNT_EN to add the period_cnt/period_len measurement outputs.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
  parameter int               GALOIS = 0,
  parameter int               STEPS  = 1
) (
  input logic       clk,
  input logic       rst,
  lfsr_gen_if.slave bus
);

  localparam logic [WIDTH-1:0] RESET_SEED = WIDTH'(nonzero_seed(MAX_WIDTH'(SEED)));
  localparam lfsr_mode         MODE       = lfsr_mode'(GALOIS != 0);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] anchor_q, anchor_d;
  logic             max_tick_q, max_tick_d;
  logic             seed_err_q, seed_err_d;
  logic             lockup_q, lockup_d;
  logic             hit;

  // chain[k] is the state after k single shifts of state_q.
  logic [STEPS:0][WIDTH-1:0] chain;

  assign chain[0] = state_q;

  for (genvar k = 1; k <= STEPS; k++) begin : g_step
    lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .MODE  (MODE)
    ) u_step (
      .s_in  (chain[k-1]),
      .s_out (chain[k])
    );
  end

  // Any intermediate counts, so a wrap that lands mid-cycle is still reported.
  always_comb begin
    hit = 1'b0;
    for (int k = 1; k <= STEPS; k++) begin
      if (chain[k] == anchor_q) hit = 1'b1;
    end
  end

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] hit_idx;

  always_comb begin
    hit_idx = '0;
    for (int k = STEPS; k >= 1; k--) begin
      if (chain[k] == anchor_q) hit_idx = WIDTH'(k);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    anchor_d   = anchor_q;
    max_tick_d = 1'b0;
    seed_err_d = 1'b0;
    lockup_d   = 1'b0;
`ifdef LFSR_PERIOD_CNT_EN
    cnt_d      = cnt_q;
    len_d      = len_q;
`endif
    if (bus.load) begin
      state_d    = (bus.seed_in == '0) ? WIDTH'(1) : bus.seed_in;
      anchor_d   = state_d;
      seed_err_d = (bus.seed_in == '0);
`ifdef LFSR_PERIOD_CNT_EN
      cnt_d      = '0;
`endif
    end else if (bus.sh_en && state_q == '0) begin
      state_d  = WIDTH'(1);
      lockup_d = 1'b1;
    end else if (bus.sh_en) begin
      state_d    = chain[STEPS];
      max_tick_d = hit;
`ifdef LFSR_PERIOD_CNT_EN
      if (hit) begin
        len_d = cnt_q + hit_idx;
        cnt_d = WIDTH'(STEPS) - hit_idx;
      end else begin
        cnt_d = cnt_q + WIDTH'(STEPS);
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESET_SEED;
      anchor_q   <= RESET_SEED;
      max_tick_q <= 1'b0;
      seed_err_q <= 1'b0;
      lockup_q   <= 1'b0;
`ifdef LFSR_PERIOD_CNT_EN
      cnt_q      <= '0;
      len_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      anchor_q   <= anchor_d;
      max_tick_q <= max_tick_d;
      seed_err_q <= seed_err_d;
      lockup_q   <= lockup_d;
`ifdef LFSR_PERIOD_CNT_EN
      cnt_q      <= cnt_d;
      len_q      <= len_d;
`endif
    end
  end

  assign bus.q_out    = state_q;
  assign bus.max_tick = max_tick_q;
  assign bus.seed_err = seed_err_q;
  assign bus.lockup   = lockup_q;
`ifdef LFSR_PERIOD_CNT_EN
  assign bus.period_cnt = cnt_q;
  assign bus.period_len = len_q;
`endif

endmodule
